// File: rtl/signed_extrema_tracker_pkg.sv
// Shared types for the signed extrema tracker: FSM state encoding and the
// one-hot {g,e,l} compare result codes used by the top level.
package signed_extrema_tracker_pkg;

    // Window FSM: waiting for first sample, accumulating, holding a result.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_RPT  = 2'd2
    } state_t;

    // Compare result packed as {g, e, l}; exactly one bit is ever set.
    typedef logic [2:0] cmp_res_t;

    localparam cmp_res_t CMP_G = 3'b100;
    localparam cmp_res_t CMP_E = 3'b010;
    localparam cmp_res_t CMP_L = 3'b001;

endpackage : signed_extrema_tracker_pkg

// File: rtl/signed_extrema_tracker_signed_cmp.sv
// Combinational signed two's-complement comparator: reports whether a is
// greater than, equal to or less than b. Exactly one of g/e/l is high.
module signed_cmp #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             g,
    output logic             e,
    output logic             l
);

    // Differing sign bits: the negative operand is smaller. Same sign: the
    // unsigned order of the full word matches the signed order.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        g = 1'b0;
        e = 1'b0;
        l = 1'b0;
        if (a == b) begin
            e = 1'b1;
        end else if (a[WIDTH-1] != b[WIDTH-1]) begin
            if (a[WIDTH-1]) l = 1'b1;
            else            g = 1'b1;
        end else if (a > b) begin
            g = 1'b1;
        end else begin
            l = 1'b1;
        end
    end

endmodule : signed_cmp

// File: rtl/signed_extrema_tracker.sv
// Signed extrema tracker: consumes a valid/ready stream of signed samples and
// reports, per window of WIN samples (or fewer when flushed), the maximum,
// the minimum, how often the maximum occurred and the sample count.
module signed_extrema_tracker
    import signed_extrema_tracker_pkg::*;
#(
    parameter  int WIDTH = 4,
    parameter  int WIN   = 8,
    localparam int CNT_W = $clog2(WIN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_max,
    output logic [WIDTH-1:0] out_min,
    output logic [CNT_W-1:0] out_nmax,
    output logic [CNT_W-1:0] out_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_WIN = CNT_W'(WIN);

    state_t           state;
    logic             accept;
    logic [CNT_W-1:0] cnt_inc;
    logic             max_g, max_e, max_l;
    logic             min_g, min_e, min_l;
    cmp_res_t         max_res;
    cmp_res_t         min_res;

    // The block stalls input only while a result is waiting to be taken.
    assign in_ready = (state != ST_RPT);
    assign accept   = in_valid & in_ready;
    assign cnt_inc  = out_cnt + CNT_ONE;

    // Incoming sample against the running maximum.
    signed_cmp #(.WIDTH(WIDTH)) u_cmp_max (
        .a (in_data),
        .b (out_max),
        .g (max_g),
        .e (max_e),
        .l (max_l)
    );

    // Incoming sample against the running minimum.
    signed_cmp #(.WIDTH(WIDTH)) u_cmp_min (
        .a (in_data),
        .b (out_min),
        .g (min_g),
        .e (min_e),
        .l (min_l)
    );

    assign max_res = {max_g, max_e, max_l};
    assign min_res = {min_g, min_e, min_l};

    // Window FSM; the running statistics double as the held output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: async reset clears every register; a partial window is simply dropped.
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            out_max   <= '0;
            out_min   <= '0;
            out_nmax  <= '0;
            out_cnt   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            unique case (state)
                ST_IDLE: begin
                    // First sample seeds both extrema; empty flushes are ignored.
                    if (accept) begin
                        out_max  <= in_data;
                        out_min  <= in_data;
                        out_cnt  <= CNT_ONE;
                        out_nmax <= CNT_ONE;
                        if (WIN == 1 || flush) begin
                            state     <= ST_RPT;
                            out_valid <= 1'b1;
                        end else begin
                            state <= ST_ACC;
                        end
                    end
                end

                ST_ACC: begin
                    if (accept) begin
                        unique case (max_res)
                            CMP_G: begin
                                out_max  <= in_data;
                                out_nmax <= CNT_ONE;
                            end
                            CMP_E:   out_nmax <= out_nmax + CNT_ONE;
                            default: ;
                        endcase
                        if (min_res == CMP_L) out_min <= in_data;
                        out_cnt <= cnt_inc;
                        if (cnt_inc == CNT_WIN || flush) begin
                            state     <= ST_RPT;
                            out_valid <= 1'b1;
                        end
                    end else if (flush) begin
                        state     <= ST_RPT;
                        out_valid <= 1'b1;
                    end
                end

                ST_RPT: begin
                    // Result held stable until the consumer takes it.
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule : signed_extrema_tracker

// File: tb/tb_signed_extrema_tracker.sv
// Directed bench for signed_extrema_tracker: one instance with WIN=4 and one
// with WIN=1, both WIDTH=4. Inputs change and outputs are sampled on the
// falling clock edge.
module tb_signed_extrema_tracker;

    logic       clk;
    logic       rst_n;

    // WIN=4 instance
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       flush;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_max;
    logic [3:0] out_min;
    logic [2:0] out_nmax;
    logic [2:0] out_cnt;

    // WIN=1 instance
    logic       in_valid1;
    logic       in_ready1;
    logic [3:0] in_data1;
    logic       flush1;
    logic       out_valid1;
    logic       out_ready1;
    logic [3:0] out_max1;
    logic [3:0] out_min1;
    logic [0:0] out_nmax1;
    logic [0:0] out_cnt1;

    int checks = 0;
    int errors = 0;

    signed_extrema_tracker #(.WIDTH(4), .WIN(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_max   (out_max),
        .out_min   (out_min),
        .out_nmax  (out_nmax),
        .out_cnt   (out_cnt)
    );

    signed_extrema_tracker #(.WIDTH(4), .WIN(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .in_data   (in_data1),
        .flush     (flush1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .out_max   (out_max1),
        .out_min   (out_min1),
        .out_nmax  (out_nmax1),
        .out_cnt   (out_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Offer one sample (optionally with flush) for the next rising edge.
    task automatic send(input logic [3:0] d, input logic fl);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        flush    = fl;
    endtask

    // Drop all stimulus; outputs registered by the previous edge are now visible.
    task automatic settle();
        @(negedge clk);
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [3:0] mx, input logic [3:0] mn,
                                input logic [2:0] nm, input logic [2:0] cn);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_ready"}, 32'(in_ready),  32'd0);
        check({tag, "_max"},   32'(out_max),   32'(mx));
        check({tag, "_min"},   32'(out_min),   32'(mn));
        check({tag, "_nmax"},  32'(out_nmax),  32'(nm));
        check({tag, "_cnt"},   32'(out_cnt),   32'(cn));
    endtask

    // Hand the result to the consumer for one edge and confirm it is gone.
    task automatic take(input string tag);
        out_ready = 1'b1;
        settle();
        check({tag, "_taken"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        flush      = 1'b0;
        out_ready  = 1'b0;
        in_valid1  = 1'b0;
        in_data1   = '0;
        flush1     = 1'b0;
        out_ready1 = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_max",   32'(out_max),   32'd0);
        check("rst_min",   32'(out_min),   32'd0);
        check("rst_nmax",  32'(out_nmax),  32'd0);
        check("rst_cnt",   32'(out_cnt),   32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'(in_ready), 32'd1);

        // 1: mixed signs, minimum is the most negative value
        send(4'b0011, 0); send(4'b1110, 0); send(4'b0111, 0);
        send(4'b1000, 0);
        settle();
        check_result("t1", 4'b0111, 4'b1000, 3'd1, 3'd4);
        take("t1");

        // 2: repeated maximum, negative minimum
        send(4'b0101, 0); send(4'b0101, 0); send(4'b1111, 0);
        send(4'b0101, 0);
        settle();
        check_result("t2", 4'b0101, 4'b1111, 3'd3, 3'd4);
        take("t2");

        // 3: short window closed by a bare flush
        send(4'b1101, 0); send(4'b1101, 0);
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b1;
        settle();
        check_result("t3", 4'b1101, 4'b1101, 3'd2, 3'd2);
        take("t3");
        // flush in IDLE must not produce an empty result
        @(negedge clk);
        flush = 1'b1;
        settle();
        check("t3_idle_flush", 32'(out_valid), 32'd0);
        settle();
        check("t3_idle_flush2", 32'(out_valid), 32'd0);
        // flush together with the first sample closes a one-sample window
        send(4'b0010, 1);
        settle();
        check_result("t3b", 4'b0010, 4'b0010, 3'd1, 3'd1);
        take("t3b");

        // 4: back-pressure while a result is pending
        send(4'b0001, 0); send(4'b0010, 0); send(4'b0011, 0);
        send(4'b0100, 0);
        @(negedge clk);
        in_data  = 4'b0110;
        flush    = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_result($sformatf("t4_hold%0d", i), 4'b0100, 4'b0001, 3'd1, 3'd4);
            @(negedge clk);
        end
        check_result("t4_hold5", 4'b0100, 4'b0001, 3'd1, 3'd4);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("t4_released", 32'(out_valid), 32'd0);
        check("t4_ready_back", 32'(in_ready), 32'd1);
        // the pending sample 0110 is accepted on this edge; close with flush
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b1;
        settle();
        check_result("t4_kept", 4'b0110, 4'b0110, 3'd1, 3'd1);
        take("t4");

        // 5: reset mid-window discards the partial window
        send(4'b0111, 0); send(4'b0111, 0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("t5_rst_valid", 32'(out_valid), 32'd0);
        check("t5_rst_max",   32'(out_max),   32'd0);
        check("t5_rst_min",   32'(out_min),   32'd0);
        check("t5_rst_nmax",  32'(out_nmax),  32'd0);
        check("t5_rst_cnt",   32'(out_cnt),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send(4'b1111, 0); send(4'b0000, 0); send(4'b0001, 0);
        send(4'b1111, 0);
        settle();
        check_result("t5", 4'b0001, 4'b1111, 3'd1, 3'd4);
        take("t5");

        // 6: WIN=1, every sample is its own window
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid1 = 1'b1;
            in_data1  = 4'b1001;
            @(negedge clk);
            in_valid1 = 1'b0;
            check($sformatf("t6_valid%0d", i), 32'(out_valid1), 32'd1);
            check($sformatf("t6_max%0d", i),   32'(out_max1),   32'h9);
            check($sformatf("t6_min%0d", i),   32'(out_min1),   32'h9);
            check($sformatf("t6_nmax%0d", i),  32'(out_nmax1),  32'd1);
            check($sformatf("t6_cnt%0d", i),   32'(out_cnt1),   32'd1);
            out_ready1 = 1'b1;
            @(negedge clk);
            out_ready1 = 1'b0;
            check($sformatf("t6_taken%0d", i), 32'(out_valid1), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_signed_extrema_tracker
